// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam logic [1:0] ADDR_TXDATA = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;

   // STATUS word layout: {count[3:0], 1'b0, empty, full, tx_busy}
   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_FULL    = 1;
   localparam int unsigned ST_EMPTY   = 2;
   localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the UART: store/read decode inputs, read data and pipeline stall.
interface uart_tx_mmio_if;

   logic        cs;
   logic        wr_en;
   logic [1:0]  addr;
   logic [7:0]  wdata;
   logic [31:0] rdata;
   logic        stall;

   modport master (
      output cs, wr_en, addr, wdata,
      input  rdata, stall
   );

   modport slave (
      input  cs, wr_en, addr, wdata,
      output rdata, stall
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with power-of-two depth; pointers wrap naturally, count is one bit wider.
module uart_tx_fifo #(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pop,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, stall generation, TX FIFO and serialiser FSM.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_mmio_if.slave bus,
   output logic          tx,
   output logic          tx_busy
);

   localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   tx_state_t       state;
   logic [15:0]     baud;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            baud_done;

   logic            push_req;
   logic            push;
   logic            pop;
   logic [7:0]      fifo_dout;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [3:0]      cnt4;

   assign push_req  = bus.cs & bus.wr_en & (bus.addr == ADDR_TXDATA);
   assign push      = push_req & ~full;
   assign pop       = (state == IDLE) & ~empty;
   // Stall follows the registered count, so a same-cycle pop still holds the store one cycle.
   assign bus.stall = push_req & full;
   assign baud_done = (baud == BAUD_LAST);
   assign cnt4      = 4'(count);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (bus.wdata),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      bus.rdata = '0;
      if (bus.cs && bus.addr == ADDR_STATUS) begin
         bus.rdata[ST_BUSY]            = tx_busy;
         bus.rdata[ST_FULL]            = full;
         bus.rdata[ST_EMPTY]           = empty;
         bus.rdata[ST_CNT_LSB +: 4]    = cnt4;
      end
   end

   // tx and tx_busy are updated on the same edge as state so the pin never glitches.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (!empty) begin
                  shift   <= fifo_dout;
                  baud    <= '0;
                  state   <= START;
                  tx      <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            START: begin
               if (baud_done) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx      <= shift[0];
               end else begin
                  baud <= baud + 16'd1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + 16'd1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud    <= '0;
                  state   <= IDLE;
                  tx_busy <= 1'b0;
               end else begin
                  baud <= baud + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, with an 8-entry byte FIFO and an 8N1 serialiser. It is the producer of the pipeline `stall` signal. When a store to TXDATA finds the FIFO full, the block asserts `stall`, and every pipeline register (including the 3-bit control registers) holds its value until a slot frees. It sits beside data memory in the MEM stage; `tx` drives the board pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..16.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-low reset; sampled on posedge clk; 0 = reset.
cs  input  1  peripheral select from MEM-stage address decode.
wr_en  input  1  store strobe; qualified by cs.
addr  input  2  register select: 0 = TXDATA, 1 = STATUS, 2/3 = reserved.
wdata  input  8  store data (byte lane 0).
rdata  output  32  combinational read data.
stall  output  1  pipeline hold request to all pipeline registers.
tx  output  1  serial line; idle high.
tx_busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - FSM goes to IDLE; FIFO pointers and count are cleared; baud counter and bit index are cleared.
  - tx=1, tx_busy=0, stall=0.
  - Reset mid-frame aborts the frame and flushes the FIFO. tx is 1 from the next cycle.
- Push request (combinational): push_req = cs & wr_en & (addr==0).
- Stall:
  - stall = push_req & full, combinational from the registered count.
  - A pop in the same cycle does not clear stall that cycle.
  - The push happens on the first cycle with push_req & !full.
  - A stalled store is never dropped and is never duplicated.
- Push: when push_req & !full, wdata is written at wr_ptr; wr_ptr and count increment. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Writes to STATUS or reserved addresses are ignored.
- rdata:
  - When cs & addr==1: rdata = {24'b0, count[3:0], 1'b0, empty, full, tx_busy}.
  - Otherwise rdata = 0. TXDATA reads return 0.
- TX FSM (baud counter counts 0..CLKS_PER_BIT-1):
  - IDLE: tx=1. If !empty, pop the head into an 8-bit shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. The register shifts right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle between them.
  - A byte pushed into an empty FIFO while in IDLE is popped the next cycle; tx falls the cycle after the pop.
- tx is driven from a register, so there are no glitches.
- full = (count==FIFO_DEPTH); empty = (count==0). count is ceil(log2(FIFO_DEPTH))+1 bits wide.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - address constants ADDR_TXDATA=2'd0 and ADDR_STATUS=2'd1;
  - STATUS bit-position constants.
- One sub-module, uart_tx_fifo: synchronous FIFO with parameterised depth, push/pop/full/empty/count, and reset via rst.
- The FSM, baud counter and bus decode live in the top module.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
1. Reset: hold rst=0 for 2 cycles, then read STATUS -> tx=1, stall=0, tx_busy=0, rdata=32'h0000_0004.
2. Single byte: write 0xA5 to TXDATA -> tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then tx=1 for 4 cycles. tx_busy is high for exactly 40 cycles.
3. Overflow stall: write 10 bytes on consecutive cycles with no gaps.
   - Bytes 0..8 are accepted (byte 0 is popped immediately), so count reaches 8.
   - On the 10th write, stall=1 and remains high until the IDLE cycle that pops byte 1. stall=0 on the next cycle, and the 10th byte is pushed then.
   - The line emits all 10 bytes in order with no loss or duplication.
4. Status while full: in scenario 3 with the FIFO full, read STATUS -> rdata=32'h0000_0083.
5. Reset mid-frame: assert rst=0 during DATA bit 3 -> the next cycle shows tx=1, tx_busy=0, count=0, stall=0. After reset release there is no residual frame.
6. Decode: write to addr=1 and addr=3 -> no push, no stall, tx stays 1. Read addr=0 -> rdata=0. Read with cs=0 -> rdata=0.
